// File: rtl/inject_queue.sv
// Per-client injection FIFO feeding a Hoplite router; offers the head packet only while token is high.
// Optional statistics counters are enabled with `define INJECT_QUEUE_STATS_EN.
module inject_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     s_ready,
    input  logic                     token,
    output logic                     ack,
    output logic                     o_valid,
    output logic [DATA_W-1:0]        o_data,
    input  logic                     o_ready,
`ifdef INJECT_QUEUE_STATS_EN
    output logic [CNT_W-1:0]         inj_cnt,
    output logic [CNT_W-1:0]         tok_stall_cnt,
    output logic [CNT_W-1:0]         full_cnt,
`endif
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign s_ready = !full;
    assign push    = s_valid && s_ready && rst;

    // Gated by rst so no token is consumed while the queue is being flushed.
    assign o_valid = !empty && token && rst;
    assign pop     = o_valid && o_ready;
    assign ack     = pop;

    // Empty head reads as zero so never-written memory cannot leak X downstream.
    assign o_data  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

`ifdef INJECT_QUEUE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            inj_cnt       <= '0;
            tok_stall_cnt <= '0;
            full_cnt      <= '0;
        end else begin
            if (ack && (inj_cnt != '1)) begin
                inj_cnt <= inj_cnt + CNT_W'(1);
            end
            if (!empty && !token && (tok_stall_cnt != '1)) begin
                tok_stall_cnt <= tok_stall_cnt + CNT_W'(1);
            end
            if (s_valid && full && (full_cnt != '1)) begin
                full_cnt <= full_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/inject_queue.md
Name: inject_queue

Overview:
- Per-client injection buffer between a traffic source and a Hoplite router injection port.
- Buffers packets in a small FIFO and presents the head packet to the router only while the rate-limiter token is high.
- Returns the accept pulse (ack) to the token counter, so each injected packet consumes exactly one token.
- Sits directly upstream of the router and alongside the token counter, closing the valid/token/ack loop in hardware.

Parameters:
- DATA_W, 32, packet width in bits (payload plus destination fields; opaque to this block).
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- s_valid  in  1  source offers a packet.
- s_data  in  DATA_W  source packet.
- s_ready  out  1  FIFO can accept; equals !full and does not depend on o_ready.
- token  in  1  rate limiter grants injection this cycle.
- ack  out  1  packet injected this cycle; to the counter's ack input.
- o_valid  out  1  head packet offered to the router.
- o_data  out  DATA_W  head packet.
- o_ready  in  1  router accepts the injection this cycle.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0 at a clock edge):
  - Pointers and level go to 0; full=0, so s_ready=1 after reset.
  - o_valid=0 and ack=0.
  - o_data is don't-care but must not be X-propagating; memory contents are not cleared.
- Reset mid-operation discards all buffered packets. ack is 0 during every reset cycle regardless of token.
- Push: s_valid & s_ready at an edge writes s_data at the write pointer. The write pointer increments modulo DEPTH.
- Pop condition: pop = o_valid & o_ready.
  - The read pointer increments modulo DEPTH.
- o_valid, o_data and ack:
  - o_valid = !empty & token (combinational from token; no register in the token path).
  - o_data = mem[rd_ptr] whenever !empty, independent of token.
  - ack = pop (combinational). There is exactly one ack per packet leaving the block.
- Latency: a packet pushed at edge N is first visible on o_data and eligible for o_valid in the cycle after edge N. There is no empty-bypass.
- Occupancy:
  - push only: level+1.
  - pop only: level-1.
  - push and pop together (not full, not empty): level unchanged, both pointers advance.
  - Full plus pop: no push is possible that cycle because s_ready=0; s_ready returns to 1 next cycle.
  - Empty: o_valid=0 and ack=0, even with token=1 and o_ready=1.
- Token low: head packet held stable, o_valid=0, and the source may keep filling until full.
- Router back-pressure: token=1 & o_ready=0 gives o_valid=1 and ack=0, with head and o_data stable. The token is not consumed; the counter sees ack=0.
- Pointer widths: $clog2(DEPTH) bits with natural wrap. full and empty are derived from level, not pointer compare.
- Ordering is strict FIFO. No packet is dropped or duplicated.
- s_valid while s_ready=0 is ignored; the source must hold data.

Optional Feature:
- Macro INJECT_QUEUE_STATS_EN.
- When defined, three output ports are added:
  - inj_cnt [CNT_W]: increments on each ack.
  - tok_stall_cnt [CNT_W]: increments each cycle with !empty & !token.
  - full_cnt [CNT_W]: increments each cycle with s_valid & full.
- All three counters reset to 0 on rst=0 and saturate at 2^CNT_W-1 (no wrap).
- When undefined, these ports and their registers do not exist and core behaviour is identical.

Test Plan:
- Reset then idle, with rst=0 for 2 cycles and token=1, o_ready=1, s_valid=0:
  - Required: s_ready=1, o_valid=0, ack=0, level=0 throughout.
- Fill to full, with token=0 and push 5 packets 0xA0..0xA4 (DEPTH=4):
  - Required: level reaches 4, s_ready=0 after the 4th push, and 0xA4 is not accepted until a pop.
  - Required (with stats): full_cnt counts the stalled cycles.
- Drain under token pattern, from the full state (0xA0..0xA3) with o_ready=1 and token=1,1,0,1,0,1:
  - Required: ack asserts in cycles 0, 1, 3 and 5.
  - Required: o_data is 0xA0, 0xA1, 0xA2, 0xA3 on those cycles, and level ends at 0.
- Router back-pressure, with one packet 0x55 buffered, token=1 and o_ready=0 for 3 cycles, then 1:
  - Required: o_valid=1 for 4 cycles, ack=0 for the first 3 cycles and ack=1 in the 4th, then o_valid=0.
- Simultaneous push/pop, with level=2, token=1, o_ready=1 and s_valid=1 for 6 cycles:
  - Required: level stays 2, ack every cycle, output order equals input order.
- Mid-operation reset, with 3 packets buffered and rst=0 for 1 cycle while token=1 and o_ready=1:
  - Required: ack=0 in the reset cycle, then level=0 and o_valid=0 afterwards.
  - Required: the next pushed packet 0x77 is the first one output.
